// File: rtl/trace_buffer.sv
// Execution-trace capture: armed, optionally PC-triggered capture of
// (instr, pc, alu) tuples into a circular buffer, drained over valid/ready.
module trace_buffer #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter int WRAP    = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       trig_en,
  input  logic [XLEN-1:0]            trig_pc,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_alu,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [31:0]                rd_instr,
  output logic [XLEN-1:0]            rd_pc,
  output logic [XLEN-1:0]            rd_alu,
  output logic [STAMP_W-1:0]         rd_stamp,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 state,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  state_t             st;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [STAMP_W-1:0] stamp;
  logic               started;

  logic [31:0]        mem_instr [DEPTH];
  logic [XLEN-1:0]    mem_pc    [DEPTH];
  logic [XLEN-1:0]    mem_alu   [DEPTH];
  logic [STAMP_W-1:0] mem_stamp [DEPTH];

  logic full, trig_hit, push, pop, wr_en;

  always_comb begin
    full     = (count == FULL_CNT);
    trig_hit = (st == ARMED) && trig_en && in_valid && (in_pc == trig_pc);
    push     = !arm && !stop && (((st == CAPTURE) && in_valid) || trig_hit);
    pop      = rd_valid && rd_ready && !arm;
    // When full, a write needs room from a same-cycle pop or overwrite mode.
    wr_en    = push && (!full || pop || (WRAP != 0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      stamp    <= '0;
      started  <= 1'b0;
      overflow <= 1'b0;
    end else if (arm) begin
      st       <= ARMED;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      stamp    <= '0;
      started  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (st)
        ARMED: begin
          if (stop)                     st <= DONE;
          else if (!trig_en || trig_hit) st <= CAPTURE;
        end
        CAPTURE: if (stop) st <= DONE;
        default: ;
      endcase
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      // A full-buffer write either consumes a pop slot or evicts the oldest entry.
      if (pop || (wr_en && full)) rd_ptr <= rd_ptr + PW'(1);
      if (push && full && !pop) overflow <= 1'b1;
      if (wr_en && !pop && !full)  count <= count + CW'(1);
      else if (pop && !wr_en)      count <= count - CW'(1);
      if (push) started <= 1'b1;
      // Stamp runs from the first captured tuple so that entry always reads 0.
      if (push || ((st == CAPTURE) && started)) stamp <= stamp + STAMP_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
      mem_alu[wr_ptr]   <= in_alu;
      mem_stamp[wr_ptr] <= stamp;
    end
  end

  assign rd_valid = (count != '0);
  assign rd_instr = mem_instr[rd_ptr];
  assign rd_pc    = mem_pc[rd_ptr];
  assign rd_alu   = mem_alu[rd_ptr];
  assign rd_stamp = mem_stamp[rd_ptr];
  assign state    = st;

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: three configurations driven in lockstep and
// compared every cycle against a queue-based reference model.
module tb_trace_buffer;

  logic        clock = 1'b0, reset = 1'b0;
  logic        arm = 1'b0, stop = 1'b0, trig_en = 1'b0, in_valid = 1'b0, rd_ready = 1'b0;
  logic [31:0] trig_pc = '0, in_instr = '0, in_pc = '0, in_alu = '0;

  always #5 clock = ~clock;

  int compared = 0, mismatched = 0;

  logic        rv [3];
  logic [31:0] ri [3], rp [3], ra [3];
  logic [15:0] rs [3];
  logic [1:0]  so [3];
  logic        ov [3];
  logic [4:0]  cnt0;
  logic [2:0]  cnt1, cnt2;

  trace_buffer #(.XLEN(32), .DEPTH(16), .STAMP_W(16), .WRAP(0)) d16 (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_alu(in_alu),
    .rd_valid(rv[0]), .rd_ready(rd_ready), .rd_instr(ri[0]), .rd_pc(rp[0]), .rd_alu(ra[0]),
    .rd_stamp(rs[0]), .count(cnt0), .state(so[0]), .overflow(ov[0]));

  trace_buffer #(.XLEN(32), .DEPTH(4), .STAMP_W(16), .WRAP(0)) d4s (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_alu(in_alu),
    .rd_valid(rv[1]), .rd_ready(rd_ready), .rd_instr(ri[1]), .rd_pc(rp[1]), .rd_alu(ra[1]),
    .rd_stamp(rs[1]), .count(cnt1), .state(so[1]), .overflow(ov[1]));

  trace_buffer #(.XLEN(32), .DEPTH(4), .STAMP_W(16), .WRAP(1)) d4w (
    .clock(clock), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_alu(in_alu),
    .rd_valid(rv[2]), .rd_ready(rd_ready), .rd_instr(ri[2]), .rd_pc(rp[2]), .rd_alu(ra[2]),
    .rd_stamp(rs[2]), .count(cnt2), .state(so[2]), .overflow(ov[2]));

  // Reference model: a queue of captured tuples per configuration.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [15:0] stamp;
  } ent_t;

  ent_t   q0[$], q1[$], q2[$];
  int     m_st [3];
  bit     m_ov [3];
  longint m_first [3];
  longint cyc = 0;
  int     depth [3] = '{16, 4, 4};
  bit     wrapm [3] = '{1'b0, 1'b0, 1'b1};

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_ov[i] = 1'b0; m_first[i] = -1;
    end
  endtask

  task automatic model_step(input int i);
    ent_t q[$];
    ent_t e;
    bit   push, pop;
    push = 1'b0;
    case (i)
      0:       q = q0;
      1:       q = q1;
      default: q = q2;
    endcase
    if (arm) begin
      q.delete(); m_ov[i] = 1'b0; m_first[i] = -1; m_st[i] = 1;
    end else begin
      pop = (q.size() != 0) && rd_ready;
      if (stop && (m_st[i] == 1 || m_st[i] == 2)) m_st[i] = 3;
      else if (m_st[i] == 1) begin
        if (!trig_en) m_st[i] = 2;
        else if (in_valid && in_pc == trig_pc) begin push = 1'b1; m_st[i] = 2; end
      end else if (m_st[i] == 2) push = in_valid;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (m_first[i] < 0) m_first[i] = cyc;
        e = '{instr: in_instr, pc: in_pc, alu: in_alu, stamp: 16'(cyc - m_first[i])};
        if (q.size() < depth[i]) q.push_back(e);
        else begin
          m_ov[i] = 1'b1;
          if (wrapm[i]) begin void'(q.pop_front()); q.push_back(e); end
        end
      end
    end
    case (i)
      0:       q0 = q;
      1:       q1 = q;
      default: q2 = q;
    endcase
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    ent_t       q[$];
    logic [4:0] c;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin q = q0; c = cnt0; end
        1:       begin q = q1; c = {2'b00, cnt1}; end
        default: begin q = q2; c = {2'b00, cnt2}; end
      endcase
      check($sformatf("d%0d.state", i),    64'(so[i]), 64'(m_st[i]));
      check($sformatf("d%0d.count", i),    64'(c),     64'(q.size()));
      check($sformatf("d%0d.overflow", i), 64'(ov[i]), 64'(m_ov[i]));
      check($sformatf("d%0d.rd_valid", i), 64'(rv[i]), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check($sformatf("d%0d.rd_pc", i),    64'(rp[i]), 64'(q[0].pc));
        check($sformatf("d%0d.rd_instr", i), 64'(ri[i]), 64'(q[0].instr));
        check($sformatf("d%0d.rd_alu", i),   64'(ra[i]), 64'(q[0].alu));
        check($sformatf("d%0d.rd_stamp", i), 64'(rs[i]), 64'(q[0].stamp));
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    for (int i = 0; i < 3; i++) model_step(i);
    cyc++;
    @(negedge clock);
    check_all();
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_arm(input logic te, input logic [31:0] tpc);
    trig_en = te; trig_pc = tpc; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic push_pc(input logic [31:0] pc);
    in_valid = 1'b1; in_pc = pc; in_instr = $urandom; in_alu = $urandom;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // Reset in the middle of a capture
    pulse_arm(1'b0, '0);
    tick();
    for (int k = 0; k < 3; k++) push_pc(32'(k * 4));
    do_reset();

    // Immediate capture, then drain
    pulse_arm(1'b0, '0);
    tick();
    for (int k = 0; k < 5; k++) push_pc(32'(k * 4));
    rd_ready = 1'b1;
    repeat (6) tick();
    rd_ready = 1'b0;

    // PC trigger at 0x20
    pulse_arm(1'b1, 32'h20);
    for (int pc = 0; pc <= 48; pc += 4) push_pc(32'(pc));
    rd_ready = 1'b1;
    repeat (6) tick();
    rd_ready = 1'b0;

    // Six pushes with no pops: stop-on-full vs keep-latest
    pulse_arm(1'b0, '0);
    tick();
    for (int k = 0; k < 6; k++) push_pc(32'(k * 4));
    rd_ready = 1'b1;
    repeat (5) tick();
    rd_ready = 1'b0;

    // Full buffer with push and pop in one cycle
    pulse_arm(1'b0, '0);
    tick();
    for (int k = 0; k < 4; k++) push_pc(32'(k * 4));
    in_valid = 1'b1; in_pc = 32'd100; in_instr = $urandom; in_alu = $urandom; rd_ready = 1'b1;
    tick();
    in_valid = 1'b0; rd_ready = 1'b0;

    // arm together with stop and a pending pop, then stop while armed
    arm = 1'b1; stop = 1'b1; rd_ready = 1'b1;
    tick();
    arm = 1'b0; rd_ready = 1'b0;
    tick();
    stop = 1'b0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      arm      = ($urandom_range(0, 39) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      trig_en  = $urandom_range(0, 1) != 0;
      trig_pc  = 32'(4 * $urandom_range(0, 7));
      in_valid = ($urandom_range(0, 3) != 0);
      in_pc    = 32'(4 * $urandom_range(0, 7));
      in_instr = $urandom;
      in_alu   = $urandom;
      rd_ready = ($urandom_range(0, 2) == 0);
      if (n == 400) do_reset();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
